text_vram_arbiter: RTL and testbench
====================================

Name: text_vram_arbiter

Overview:
- Shares one single-port, synchronous-read character RAM (text buffer) between three requesters, in fixed priority:
  1. The display character-fetch path, which is time-critical and driven from the pixel-clock sync counters.
  2. A built-in clear/fill engine.
  3. A host write/read port using a valid/ready handshake.
- Sits between the text-mode pixel pipeline and the VRAM.
- Guarantees the display a fixed-latency read slot every cycle it requests one.

Parameters:
- ADDR_W, 12, VRAM address width.
- DATA_W, 8, character code width.
- DEPTH, 2400, number of cells the clear engine fills (80x30); must be <= 2^ADDR_W.
- CLEAR_ON_RESET, 1, if 1 the block enters CLEAR on reset; if 0 it enters IDLE.

Ports:
- clk, input, 1: pixel clock; all logic rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- disp_req, input, 1: display read request for this cycle.
- disp_addr, input, ADDR_W: display read address.
- disp_data, output, DATA_W: registered display read data.
- disp_data_valid, output, 1: one-cycle pulse; disp_data was updated this cycle.
- host_valid, input, 1: host request.
- host_ready, output, 1: host request accepted this cycle.
- host_we, input, 1: 1 = write, 0 = read.
- host_addr, input, ADDR_W: host address.
- host_wdata, input, DATA_W: host write data.
- host_rdata, output, DATA_W: registered host read data.
- host_rvalid, output, 1: one-cycle pulse; host_rdata was updated this cycle.
- fill_char, input, DATA_W: value written by the clear engine; sampled each clear write.
- clr_start, input, 1: pulse that starts a clear.
- clr_busy, output, 1: high while in CLEAR.
- ram_en, output, 1: RAM access enable.
- ram_we, output, 1: RAM write enable.
- ram_addr, output, ADDR_W: RAM address.
- ram_wdata, output, DATA_W: RAM write data.
- ram_rdata, input, DATA_W: RAM read data, valid 1 cycle after a read access.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - disp_data, host_rdata, disp_data_valid, host_rvalid, clear address counter, read-tag pipeline: all 0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE; clr_busy follows state, including during reset.
  - ram_en, ram_we and host_ready are forced 0 combinationally while rst_n is low.
- Per-cycle grant (combinational mux onto the ram_* ports), in priority order:
  - disp_req=1: read at disp_addr.
  - Else, state=CLEAR: write fill_char at the clear address.
  - Else, host_valid=1 and state=IDLE: access at host_addr; ram_we=host_we.
  - Otherwise ram_en=0.
- host_ready = host_valid & !disp_req & (state==IDLE) & rst_n.
  - A transfer occurs when host_valid & host_ready.
  - The host must hold host_valid, host_we, host_addr and host_wdata stable until it sees host_ready.
- Read latency:
  - A granted read is tagged DISP or HOST in a 1-stage tag register.
  - In the next cycle, ram_rdata is captured into the tagged output register.
  - The matching *_valid signal pulses in the cycle after capture.
  - Net: request accepted at cycle N -> data and valid visible at N+2.
  - Outputs hold their value between pulses.
  - Host writes produce no host_rvalid.
- Back-to-back reads: one per cycle with no bubbles. Display and host returns may interleave; tags keep them separate.
- FSM:
  - IDLE -> CLEAR on clr_start.
  - CLEAR: the address counter starts at 0 and increments only on cycles in which the clear write is granted (disp_req=0).
  - After writing address DEPTH-1: counter returns to 0 and the state goes to IDLE in the following cycle; clr_busy falls in that same cycle.
  - clr_start during CLEAR is ignored (no restart).
  - Total clear time = DEPTH + number of disp_req cycles during the clear.
- Addresses: passed through unchecked. Out-of-range addresses are the RAM's concern. No wrap logic beyond the ADDR_W width.
- Reset during CLEAR or during an outstanding read:
  - Pending valid pulses are dropped.
  - The FSM restarts per CLEAR_ON_RESET.
- Simultaneous disp_req and host_valid: display wins; host_ready=0 and the host waits.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds:
  - Output host_stall_cnt (16 bits).
  - Input stall_clr (1 bit).
- host_stall_cnt behaviour:
  - Increments each cycle with host_valid=1 and host_ready=0, while rst_n is high.
  - Saturates at 16'hFFFF.
  - Cleared by stall_clr, which takes priority over increment.
  - Reset value 0.
- When not defined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
1. CLEAR_ON_RESET=1, DEPTH=2400, fill_char=8'h20, no requests -> clr_busy high from reset; exactly 2400 writes to addresses 0..2399 with data 8'h20, one per cycle; clr_busy falls; host_ready is 1 when host_valid=1.
2. Same as 1 with disp_req high 1 cycle in 8 -> every disp_req cycle is a RAM read at disp_addr; clear writes remain contiguous 0..2399; clear length = 2400 + disp_req count.
3. Host write 8'h41 to 12'h005, then host read of 12'h005 -> host_rvalid pulses exactly 2 cycles after the read is accepted, with host_rdata=8'h41; no host_rvalid after the write.
4. host_valid held while disp_req is high for 3 cycles -> host_ready=0 for those 3 cycles and accepted on the 4th; each disp_data_valid arrives at request+2 with the correct data; no host/display data crossover.
5. clr_start from IDLE with host_valid high; then assert rst_n low at clear address 1000 -> host stalled while clr_busy=1; ram_en=0 immediately on reset; after release the clear restarts at address 0.
6. With VRAM_ARB_STATS_EN defined: stall the host 5 cycles -> host_stall_cnt=5; pulse stall_clr -> 0; force 70000 stall cycles -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/text_vram_arbiter.sv
// Fixed-priority arbiter (display > clear engine > host) for a single-port sync-read text RAM; read data and valid appear 2 cycles after grant.
// Host is backpressured via host_ready; optional stall counter under `VRAM_ARB_STATS_EN`.
module text_vram_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 2400,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic [DATA_W-1:0] fill_char,
  input  logic              clr_start,
  output logic              clr_busy,
`ifdef VRAM_ARB_STATS_EN
  input  logic              stall_clr,
  output logic [15:0]       host_stall_cnt,
`endif
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
  logic              w_disp_gnt, w_clr_gnt, w_host_gnt;
  logic              r_tag_disp, r_tag_host;
  logic [DATA_W-1:0] r_disp_data, r_host_data;
  logic              r_disp_vld, r_host_vld;

  always_comb begin
    w_disp_gnt = disp_req;
    w_clr_gnt  = !disp_req && (r_state == S_CLEAR);
    w_host_gnt = !disp_req && (r_state == S_IDLE) && host_valid;
  end

  // Enables are gated by rst_n so the RAM sees no access while reset is held.
  assign ram_en     = rst_n & (w_disp_gnt | w_clr_gnt | w_host_gnt);
  assign ram_we     = rst_n & (w_clr_gnt | (w_host_gnt & host_we));
  assign ram_wdata  = w_clr_gnt ? fill_char : host_wdata;
  assign host_ready = rst_n & w_host_gnt;
  assign clr_busy   = (r_state == S_CLEAR);

  always_comb begin
    ram_addr = host_addr;
    if (w_disp_gnt) begin
      ram_addr = disp_addr;
    end else if (w_clr_gnt) begin
      ram_addr = r_clr_addr;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        // Counter only advances on granted writes, so display reads stretch the clear.
        if (w_clr_gnt) begin
          if (r_clr_addr == LAST_ADDR) begin
            w_state_nxt    = S_IDLE;
            w_clr_addr_nxt = '0;
          end else begin
            w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_clr_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // One-stage tag travels alongside the RAM read so returns route to the right requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_disp  <= 1'b0;
      r_tag_host  <= 1'b0;
      r_disp_vld  <= 1'b0;
      r_host_vld  <= 1'b0;
      r_disp_data <= '0;
      r_host_data <= '0;
    end else begin
      r_tag_disp <= w_disp_gnt;
      r_tag_host <= w_host_gnt & !host_we;
      r_disp_vld <= r_tag_disp;
      r_host_vld <= r_tag_host;
      if (r_tag_disp) begin
        r_disp_data <= ram_rdata;
      end
      if (r_tag_host) begin
        r_host_data <= ram_rdata;
      end
    end
  end

  assign disp_data       = r_disp_data;
  assign disp_data_valid = r_disp_vld;
  assign host_rdata      = r_host_data;
  assign host_rvalid     = r_host_vld;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (host_valid && !host_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign host_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Bench for text_vram_arbiter: grant table, scoreboard for tagged read returns, clear/reset sequences.
module tb_text_vram_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2400;

  logic          clk, rst_n;
  logic          disp_req, disp_data_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          host_valid, host_ready, host_we, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [DW-1:0] fill_char;
  logic          clr_start, clr_busy;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic          stall_clr;
  logic [15:0]   host_stall_cnt;
`endif

  text_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .fill_char(fill_char), .clr_start(clr_start), .clr_busy(clr_busy),
`ifdef VRAM_ARB_STATS_EN
    .stall_clr(stall_clr), .host_stall_cnt(host_stall_cnt),
`endif
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural single-port synchronous-read RAM
  logic [DW-1:0] mem    [4096];
  logic [DW-1:0] shadow [4096];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q_disp[$];
  exp_t q_host[$];
  exp_t e_push, e_pop;

  // Scoreboard: expectations pushed on acceptance, popped when due (two cycles later).
  always @(negedge clk) begin
    if (!rst_n) begin
      q_disp.delete();
      q_host.delete();
    end else begin
      if (q_disp.size() > 0 && q_disp[0].due == cyc) begin
        e_pop = q_disp.pop_front();
        check("disp_rvalid", {31'd0, disp_data_valid}, 32'd1);
        check("disp_rdata", {24'd0, disp_data}, {24'd0, e_pop.data});
      end else if (disp_data_valid) begin
        check("disp_rvalid_spurious", {31'd0, disp_data_valid}, 32'd0);
      end
      if (q_host.size() > 0 && q_host[0].due == cyc) begin
        e_pop = q_host.pop_front();
        check("host_rvalid", {31'd0, host_rvalid}, 32'd1);
        check("host_rdata", {24'd0, host_rdata}, {24'd0, e_pop.data});
      end else if (host_rvalid) begin
        check("host_rvalid_spurious", {31'd0, host_rvalid}, 32'd0);
      end
      if (disp_req) begin
        e_push.data = shadow[disp_addr];
        e_push.due  = cyc + 2;
        q_disp.push_back(e_push);
      end
      if (host_valid && host_ready) begin
        if (host_we) begin
          shadow[host_addr] = host_wdata;
        end else begin
          e_push.data = shadow[host_addr];
          e_push.due  = cyc + 2;
          q_host.push_back(e_push);
        end
      end
    end
  end

  typedef struct {
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          hv, hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rdy;
  } vec_t;

  vec_t vt[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int writes, bad, nclr, ndr, busy, stall_bad, found;

    vt[0]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'hFF0, 8'hA1, 1'b1, 1'b1, 12'hFF0, 8'hA1, 1'b1};
    vt[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'hFF1, 8'hB2, 1'b1, 1'b1, 12'hFF1, 8'hB2, 1'b1};
    vt[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'hFF2, 8'hC3, 1'b1, 1'b1, 12'hFF2, 8'hC3, 1'b1};
    vt[4]  = '{1'b1, 12'hFF0, 1'b1, 1'b1, 12'h010, 8'h55, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hFF1, 8'h00, 1'b1, 1'b0, 12'hFF1, 8'h00, 1'b1};
    vt[6]  = '{1'b1, 12'hFF2, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'hFF2, 8'h00, 1'b0};
    vt[7]  = '{1'b1, 12'hFF0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b0};
    vt[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b1};
    vt[9]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7FF, 8'h5A, 1'b1, 1'b1, 12'h7FF, 8'h5A, 1'b1};
    vt[10] = '{1'b1, 12'h7FF, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h7FF, 8'h00, 1'b0};
    vt[11] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1};
    vt[12] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};

    for (int a = 0; a < 4096; a++) begin
      mem[a]    = '0;
      shadow[a] = '0;
    end

    // Reset with requests active: enables and handshake must stay low
    rst_n = 1'b0; disp_req = 1'b1; disp_addr = '0; host_valid = 1'b1; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; fill_char = 8'h20; clr_start = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    stall_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_clr_busy", {31'd0, clr_busy}, 32'd1);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd0);
    check("rst_disp_valid", {31'd0, disp_data_valid}, 32'd0);
    check("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_disp_data", {24'd0, disp_data}, 32'd0);
    check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    for (int a = 0; a < DEPTH; a++) shadow[a] = 8'h20;
    tick();
    disp_req = 1'b0; host_valid = 1'b0; rst_n = 1'b1;

    // Clear from reset, no competing requests
    writes = 0; bad = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (!(ram_en && ram_we && ram_addr == AW'(writes) && ram_wdata == 8'h20)) bad++;
      writes++;
    end
    check("t1_clear_writes", writes, DEPTH);
    check("t1_clear_bad", bad, 0);
    tick();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    @(negedge clk);
    check("t1_host_ready", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0;

    // Grant mux vectors, back-to-back mixed reads
    for (int i = 0; i < 13; i++) begin
      disp_req = vt[i].dreq; disp_addr = vt[i].daddr;
      host_valid = vt[i].hv; host_we = vt[i].hwe; host_addr = vt[i].haddr; host_wdata = vt[i].hwd;
      @(negedge clk);
      check($sformatf("vec%0d_en", i), {31'd0, ram_en}, {31'd0, vt[i].e_en});
      check($sformatf("vec%0d_we", i), {31'd0, ram_we}, {31'd0, vt[i].e_we});
      check($sformatf("vec%0d_rdy", i), {31'd0, host_ready}, {31'd0, vt[i].e_rdy});
      if (vt[i].e_en) check($sformatf("vec%0d_addr", i), {20'd0, ram_addr}, {20'd0, vt[i].e_addr});
      if (vt[i].e_we) check($sformatf("vec%0d_wdata", i), {24'd0, ram_wdata}, {24'd0, vt[i].e_wd});
      tick();
    end
    disp_req = 1'b0; host_valid = 1'b0;
    repeat (3) tick();

    // Host write then read-back of 0x005
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h005; host_wdata = 8'h41;
    @(negedge clk);
    check("t3_wr_ready", {31'd0, host_ready}, 32'd1);
    tick();
    host_we = 1'b0;
    @(negedge clk);
    check("t3_rd_ready", {31'd0, host_ready}, 32'd1);
    check("t3_no_rvalid_wr1", {31'd0, host_rvalid}, 32'd0);
    tick();
    host_valid = 1'b0;
    @(negedge clk);
    check("t3_no_rvalid_wr2", {31'd0, host_rvalid}, 32'd0);
    @(negedge clk);
    check("t3_rvalid_n2", {31'd0, host_rvalid}, 32'd1);
    check("t3_rdata_n2", {24'd0, host_rdata}, 32'h41);
    tick();

    // Host held off by three display cycles
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = 12'hFF0 + AW'(i);
      @(negedge clk);
      check($sformatf("t4_blocked%0d", i), {31'd0, host_ready}, 32'd0);
      tick();
    end
    disp_req = 1'b0;
    @(negedge clk);
    check("t4_accept", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0;
    repeat (3) tick();

    // Clear interleaved with display reads one cycle in eight
    fill_char = 8'h2E;
    for (int a = 0; a < DEPTH; a++) shadow[a] = 8'h2E;
    clr_start = 1'b1;
    @(negedge clk);
    check("t2_busy_before", {31'd0, clr_busy}, 32'd0);
    tick();
    clr_start = 1'b0;
    nclr = 0; ndr = 0; busy = 0; bad = 0;
    for (int k = 0; k < 3000; k++) begin
      disp_req = (k % 8 == 7); disp_addr = 12'hFF0 + AW'(k % 4);
      @(negedge clk);
      if (!clr_busy) break;
      busy++;
      if (disp_req) begin
        ndr++;
        if (!(ram_en && !ram_we && ram_addr == disp_addr)) bad++;
      end else begin
        if (!(ram_en && ram_we && ram_addr == AW'(nclr) && ram_wdata == 8'h2E)) bad++;
        nclr++;
      end
      tick();
    end
    tick();
    disp_req = 1'b0;
    check("t2_clear_writes", nclr, DEPTH);
    check("t2_bad", bad, 0);
    check("t2_disp_count", ndr, 342);
    check("t2_length", busy, 2742);

    // Reset during clear with a display read in flight
    fill_char = 8'h20;
    for (int a = 0; a < DEPTH; a++) shadow[a] = 8'h20;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    stall_bad = 0; found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (host_ready) stall_bad++;
      if (ram_we && ram_addr == 12'd999) begin
        found = 1;
        break;
      end
    end
    check("t5_reach_999", found, 1);
    tick();
    disp_req = 1'b1; disp_addr = 12'hFF1;
    @(negedge clk);
    if (host_ready) stall_bad++;
    tick();
    disp_req = 1'b0;
    @(negedge clk);
    check("t5_addr_1000", {20'd0, ram_addr}, 32'd1000);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("t5_rst_ready", {31'd0, host_ready}, 32'd0);
    check("t5_rst_busy", {31'd0, clr_busy}, 32'd1);
    @(posedge clk);
    tick();
    check("t5_disp_data_rst", {24'd0, disp_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_restart_addr", {20'd0, ram_addr}, 32'd0);
    check("t5_restart_we", {31'd0, ram_we}, 32'd1);
    writes = 1;
    for (int k = 0; k < 3000; k++) begin
      if (host_ready) stall_bad++;
      @(negedge clk);
      if (!clr_busy) break;
      writes++;
    end
    check("t5_restart_writes", writes, DEPTH);
    check("t5_host_stalled", stall_bad, 0);
    check("t5_host_accept", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0;
    repeat (3) tick();

`ifdef VRAM_ARB_STATS_EN
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge clk);
    check("t6_cnt_clear", {16'd0, host_stall_cnt}, 32'd0);
    tick();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h005; disp_req = 1'b1; disp_addr = 12'hFF2;
    repeat (5) tick();
    host_valid = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    check("t6_cnt_5", {16'd0, host_stall_cnt}, 32'd5);
    tick();
    stall_clr = 1'b1; host_valid = 1'b1; disp_req = 1'b1;
    tick();
    stall_clr = 1'b0; host_valid = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    check("t6_clr_priority", {16'd0, host_stall_cnt}, 32'd0);
    tick();
    host_valid = 1'b1; disp_req = 1'b1;
    repeat (70000) tick();
    host_valid = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    check("t6_saturate", {16'd0, host_stall_cnt}, 32'hFFFF);
    tick();
`endif

    repeat (4) tick();
    check("sb_drained", q_disp.size() + q_host.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
